// File: rtl/key_pkg.sv
// Shared types and helpers for the key slot allocator and its lookup consumers.
// State encoding, index sizing and flat-bus slot extraction live here.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  // Upper bounds for the generic slot extractor; callers truncate to their width.
  localparam int KEY_MAX_W  = 64;
  localparam int FLAT_MAX_W = 4096;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [KEY_MAX_W-1:0] key_slot(input logic [FLAT_MAX_W-1:0] flat,
                                                    input int i,
                                                    input int w);
    logic [FLAT_MAX_W-1:0] shifted;
    shifted = flat >> (i * w);
    return shifted[KEY_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/popcount_n.sv
// N-bit population count; output width chosen by the instantiating block.
module popcount_n #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic [N-1:0]     bits,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/key_slot_alloc.sv
// Key table allocator: fixed-latency sequential scan for a duplicate or free slot,
// writes the key, returns the slot index; frees release a slot by index.
module key_slot_alloc
  import key_pkg::*;
#(
  parameter int NR_KEY    = 4,
  parameter int KEY_WIDTH = 8,
  parameter int IDX_WIDTH = idx_width(NR_KEY)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [KEY_WIDTH-1:0]        alloc_key,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [IDX_WIDTH-1:0]        resp_idx,
  output logic                        resp_hit,
  output logic                        resp_err,
  input  logic                        free_valid,
  output logic                        free_ready,
  input  logic [IDX_WIDTH-1:0]        free_idx,
  output logic [NR_KEY*KEY_WIDTH-1:0] keys,
  output logic [NR_KEY-1:0]           valid_mask,
  output logic [IDX_WIDTH:0]          count
);

  state_e               state;
  logic [IDX_WIDTH-1:0] ptr;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 found_dup;
  logic                 found_free;
  logic [IDX_WIDTH-1:0] dup_idx;
  logic [IDX_WIDTH-1:0] free_slot;

  logic [KEY_WIDTH-1:0] cur_key;
  logic                 dup_next;
  logic                 free_next;
  logic [IDX_WIDTH-1:0] dup_idx_next;
  logic [IDX_WIDTH-1:0] free_slot_next;
  logic                 last_slot;
  logic                 free_in_range;

  assign alloc_ready   = (state == IDLE);
  assign free_ready    = (state == IDLE);
  assign last_slot     = (ptr == IDX_WIDTH'(NR_KEY - 1));
  assign free_in_range = (int'(free_idx) < NR_KEY);

  // Fold the slot under the pointer into what earlier scan cycles recorded.
  always_comb begin
    cur_key        = KEY_WIDTH'(key_slot(FLAT_MAX_W'(keys), int'(ptr), KEY_WIDTH));
    dup_next       = found_dup;
    dup_idx_next   = dup_idx;
    free_next      = found_free;
    free_slot_next = free_slot;
    if (!found_dup && valid_mask[ptr] && (cur_key == key_q)) begin
      dup_next     = 1'b1;
      dup_idx_next = ptr;
    end
    if (!found_free && !valid_mask[ptr]) begin
      free_next      = 1'b1;
      free_slot_next = ptr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  // NOTE: the key table is reset because it feeds the lookup mux directly and must never be X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      key_q      <= '0;
      found_dup  <= 1'b0;
      found_free <= 1'b0;
      dup_idx    <= '0;
      free_slot  <= '0;
      keys       <= '0;
      valid_mask <= '0;
      resp_valid <= 1'b0;
      resp_idx   <= '0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (free_valid && free_in_range) begin
            valid_mask[free_idx] <= 1'b0;
          end
          if (alloc_valid) begin
            key_q      <= alloc_key;
            ptr        <= '0;
            found_dup  <= 1'b0;
            found_free <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          found_dup  <= dup_next;
          dup_idx    <= dup_idx_next;
          found_free <= free_next;
          free_slot  <= free_slot_next;
          ptr        <= ptr + IDX_WIDTH'(1);
          if (last_slot) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            if (dup_next) begin
              resp_hit <= 1'b1;
              resp_err <= 1'b0;
              resp_idx <= dup_idx_next;
            end else if (free_next) begin
              keys[KEY_WIDTH*free_slot_next +: KEY_WIDTH] <= key_q;
              valid_mask[free_slot_next] <= 1'b1;
              resp_hit <= 1'b0;
              resp_err <= 1'b0;
              resp_idx <= free_slot_next;
            end else begin
              resp_hit <= 1'b0;
              resp_err <= 1'b1;
              resp_idx <= '0;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  popcount_n #(
    .N     (NR_KEY),
    .CNT_W (IDX_WIDTH + 1)
  ) u_popcount (
    .bits (valid_mask),
    .cnt  (count)
  );

endmodule

// File: doc/key_slot_alloc.md
Name: key_slot_alloc

Overview:
Allocator and writer for the key table consumed by the key-to-index lookup mux (key in, index out). It takes a key, scans the table sequentially for a duplicate or a free slot, writes the key, and returns the slot index (index out). Frees release a slot by index. The flat key bus and the valid mask drive the lookup mux's inputs directly.

Parameters:
NR_KEY, 4, number of table slots (>=2)
KEY_WIDTH, 8, key width in bits
IDX_WIDTH, $clog2(NR_KEY), slot index width (matches lookup DATA_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  allocation request
alloc_ready  out  1  request accepted when valid&&ready
alloc_key  in  KEY_WIDTH  key to allocate
resp_valid  out  1  response available
resp_ready  in  1  response consumed when valid&&ready
resp_idx  out  IDX_WIDTH  slot holding the key (0 on err)
resp_hit  out  1  key already present, no write
resp_err  out  1  table full and key absent, no write
free_valid  in  1  release request
free_ready  out  1  release accepted when valid&&ready
free_idx  in  IDX_WIDTH  slot to release
keys  out  NR_KEY*KEY_WIDTH  slot i at [KEY_WIDTH*i +: KEY_WIDTH]
valid_mask  out  NR_KEY  bit i set = slot i occupied
count  out  IDX_WIDTH+1  popcount(valid_mask)

Behaviour:
- Reset (async assert, sync deassert): state IDLE, keys=0, valid_mask=0, count=0, resp_valid=0, resp_idx=0, resp_hit=0, resp_err=0, scan pointer=0.
- FSM IDLE -> SCAN -> RESP -> IDLE.
- IDLE: alloc_ready=1, free_ready=1. In all other states both are 0.
- Accept edge T: latch alloc_key, clear ptr, clear found_dup and found_free, then enter SCAN.
- SCAN: examine one slot per cycle (slot ptr).
  - valid && key equal: record dup idx; later duplicates ignored.
  - !valid and no free slot recorded yet: record free idx (lowest free slot wins).
  - After slot NR_KEY-1 is examined (edge T+NR_KEY), go to RESP.
  - No early exit, so latency is fixed.
- On the edge entering RESP, in priority order:
  - dup: resp_hit=1, resp_idx=dup idx, table unchanged.
  - else free: write key into that slot, set its valid bit, resp_idx=free idx.
  - else: resp_err=1, resp_idx=0.
- resp_valid is high from cycle T+NR_KEY+1. Response fields hold stable until resp_ready. The handshake edge clears resp_valid and returns the FSM to IDLE. A new accept can occur the next cycle at the earliest.
- Free accepted in IDLE: clear valid_mask[free_idx] at that edge; keys contents are kept.
  - Freeing an already-free slot is a no-op.
  - free_idx >= NR_KEY is ignored.
- Alloc and free in the same IDLE cycle: both accepted. The free applies at the accept edge, so the scan sees the slot as free.
- count is updated combinationally from valid_mask (or registered in lockstep). It never exceeds NR_KEY.
- keys and valid_mask change only at RESP entry or on a free edge.
- Async reset mid-SCAN or mid-RESP: everything returns to reset values immediately and the pending response is lost.

Decomposition:
- Shared package key_pkg: state enum (IDLE, SCAN, RESP); function idx_width(n) = $clog2(n); function key_slot(flat, i) for part-select.
- One natural sub-module, popcount_n (NR_KEY-bit popcount), reused for count.
- Key compare, pointer and FSM stay inline.

Test Plan:
- Reset, then alloc key 0x5A -> resp_valid at cycle T+5 (NR_KEY=4), idx=0, hit=0, err=0; valid_mask=0001, keys[7:0]=0x5A, count=1.
- Alloc 0x11, 0x22 then 0x11 again -> idx 1, 2, then idx=1 with hit=1; valid_mask=0111, count=3.
- Fill all 4 slots, alloc 0x99 -> err=1, idx=0, table unchanged. Free idx 2 with alloc 0x99 in the same cycle -> idx=2, hit=0.
- Hold resp_ready=0 for 3 cycles -> resp fields stable, alloc_ready=0, free_ready=0. A free_valid presented meanwhile has no effect until IDLE.
- Free slot 0 (holding 0x5A), then alloc 0x5A -> idx=0 (lowest free slot), hit=0 (stale key ignored because slot invalid).
- Assert rst_n=0 mid-SCAN -> same-cycle valid_mask=0, count=0, resp_valid=0; after release, alloc 0x33 -> idx=0.
